// File: rtl/writeback_regfile.sv
// RV32I writeback result mux + 32x32 register file with write-through reads and commit counter.
// Reads and ResultW are zero-cycle combinational; writes land on the next edge; no backpressure.
module writeback_regfile #(
    parameter int          XLEN       = 32,
    parameter int          NREGS      = 32,
    parameter int          AW         = 5,
    parameter logic [31:0] WB_CNT_RST = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [XLEN-1:0] ImmExtW,
    input  logic [AW-1:0]   RdW,
    input  logic [AW-1:0]   Rs1D,
    input  logic [AW-1:0]   Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [31:0]     WbCountW
);

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC4 = 2'b10;
    localparam logic [1:0] SRC_IMM = 2'b11;

    logic [XLEN-1:0] r_regs [0:NREGS-1];
    logic [31:0]     r_wb_count;
    logic            w_commit;
    logic [XLEN-1:0] w_result;

    always_comb begin
        w_result = ALUResultW;
        unique case (ResultSrcW)
            SRC_ALU: w_result = ALUResultW;
            SRC_MEM: w_result = ReadDataW;
            SRC_PC4: w_result = PCPlus4W;
            SRC_IMM: w_result = ImmExtW;
        endcase
    end

    assign ResultW  = w_result;
    assign w_commit = RegWriteW && (RdW != '0);

    // Entry 0 is only ever written with zero, so x0 is hard-wired by construction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= WB_CNT_RST;
        end else if (w_commit) begin
            r_regs[RdW] <= w_result;
            r_wb_count  <= r_wb_count + 32'd1;
        end
    end

    // Outputs are gated by rst_n so nothing uninitialised leaks out during the first reset cycle.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] rs);
        logic [XLEN-1:0] v;
        v = '0;
        if (rst_n && (rs != '0)) begin
            if (RegWriteW && (RdW == rs)) v = w_result;
            else                          v = r_regs[rs];
        end
        return v;
    endfunction

    assign RD1D     = read_port(Rs1D);
    assign RD2D     = read_port(Rs2D);
    assign WbCountW = rst_n ? r_wb_count : 32'h0;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed vector bench for writeback_regfile; second instance starts its counter at all-ones to exercise wrap.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW;
    logic [4:0]  RdW, Rs1D, Rs2D;
    logic [31:0] RD1D, RD2D, ResultW, WbCountW;

    logic        w_rst_n;
    logic        w_we;
    logic [4:0]  w_rd, w_rs1;
    logic [31:0] w_alu;
    logic [31:0] w_rd1, w_rd2, w_res, w_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .ImmExtW(ImmExtW), .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .WbCountW(WbCountW)
    );

    writeback_regfile #(.WB_CNT_RST(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .RegWriteW(w_we), .ResultSrcW(2'b00),
        .ALUResultW(w_alu), .ReadDataW(32'h0), .PCPlus4W(32'h0),
        .ImmExtW(32'h0), .RdW(w_rd), .Rs1D(w_rs1), .Rs2D(5'd0),
        .RD1D(w_rd1), .RD2D(w_rd2), .ResultW(w_res), .WbCountW(w_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [1:0]  src;
        logic [31:0] alu, mem, pc4, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] e_rd1, e_rd2, e_res, e_cnt;
    } vec_t;

    vec_t vecs [0:10];

    function automatic vec_t mk(input logic r, input logic we, input logic [1:0] src,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [31:0] pc4, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] er, input logic [31:0] ec);
        vec_t v;
        v.rst_n = r; v.we = we; v.src = src;
        v.alu = alu; v.mem = mem; v.pc4 = pc4; v.imm = imm;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_res = er; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        RegWriteW = 1'b0; ResultSrcW = 2'b00;
        ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0; ImmExtW = '0;
        RdW = '0; Rs1D = '0; Rs2D = '0;
    endtask

    initial begin
        //             rst we src alu           mem           pc4           imm           rd  rs1 rs2  rd1           rd2           res           cnt
        vecs[0]  = mk(1, 1, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 5, 5, 0, 32'h1234_5678, 32'h0, 32'h1234_5678, 0);
        vecs[1]  = mk(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5, 5, 32'h1234_5678, 32'h1234_5678, 32'h0, 1);
        vecs[2]  = mk(1, 1, 2'b01, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 7, 7, 7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        vecs[3]  = mk(1, 1, 2'b11, 32'h0, 32'h0, 32'h0, 32'hFFFF_F000, 0, 0, 7, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_F000, 2);
        vecs[4]  = mk(1, 1, 2'b10, 32'h0, 32'h0, 32'h0000_0104, 32'h0, 1, 0, 5, 32'h0, 32'h1234_5678, 32'h104, 2);
        vecs[5]  = mk(1, 0, 2'b11, 32'h0, 32'h0, 32'h0, 32'h0000_0ABC, 0, 1, 7, 32'h104, 32'hDEAD_BEEF, 32'hABC, 3);
        vecs[6]  = mk(1, 0, 2'b00, 32'h0000_FFFF, 32'h0, 32'h0, 32'h0, 5, 5, 1, 32'h1234_5678, 32'h104, 32'hFFFF, 3);
        vecs[7]  = mk(1, 1, 2'b00, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 5, 5, 0, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 3);
        vecs[8]  = mk(0, 1, 2'b00, 32'h5, 32'h0, 32'h0, 32'h0, 3, 5, 1, 32'h0, 32'h0, 32'h5, 0);
        vecs[9]  = mk(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5, 3, 32'h0, 32'h0, 32'h0, 0);
        vecs[10] = mk(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 7, 32'h0, 32'h0, 32'h0, 0);

        idle_inputs();
        rst_n = 1'b0;
        w_rst_n = 1'b0; w_we = 1'b0; w_rd = '0; w_rs1 = '0; w_alu = '0;

        // Reset held for two edges, with a write presented that must be lost.
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd3; ALUResultW = 32'd5; Rs1D = 5'd3;
        #1;
        check("reset_rd1", RD1D, 32'h0);
        check("reset_cnt", WbCountW, 32'h0);
        check("reset_result_mux", ResultW, 32'd5);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            Rs1D = i[4:0];
            Rs2D = 5'(32 - i);
            #1;
            check($sformatf("reset_x%0d", i), RD1D, 32'h0);
            check($sformatf("reset_x%0d_p2", 32 - i), RD2D, 32'h0);
            @(negedge clk);
        end
        check("reset_cnt_after", WbCountW, 32'h0);

        for (int i = 0; i < 11; i++) begin
            rst_n      = vecs[i].rst_n;
            RegWriteW  = vecs[i].we;
            ResultSrcW = vecs[i].src;
            ALUResultW = vecs[i].alu;
            ReadDataW  = vecs[i].mem;
            PCPlus4W   = vecs[i].pc4;
            ImmExtW    = vecs[i].imm;
            RdW        = vecs[i].rd;
            Rs1D       = vecs[i].rs1;
            Rs2D       = vecs[i].rs2;
            #1;
            check($sformatf("v%0d_rd1", i), RD1D, vecs[i].e_rd1);
            check($sformatf("v%0d_rd2", i), RD2D, vecs[i].e_rd2);
            check($sformatf("v%0d_result", i), ResultW, vecs[i].e_res);
            check($sformatf("v%0d_cnt", i), WbCountW, vecs[i].e_cnt);
            @(negedge clk);
        end
        idle_inputs();

        // Counter wrap: instance reset value is all-ones, one commit wraps to zero.
        #1;
        check("wrap_cnt_in_reset", w_cnt, 32'h0);
        @(negedge clk);
        w_rst_n = 1'b1;
        #1;
        check("wrap_cnt_preload", w_cnt, 32'hFFFF_FFFF);
        w_we = 1'b1; w_rd = 5'd2; w_alu = 32'h0000_0055; w_rs1 = 5'd2;
        #1;
        check("wrap_bypass", w_rd1, 32'h0000_0055);
        @(negedge clk);
        w_we = 1'b0; w_alu = '0;
        #1;
        check("wrap_cnt_zero", w_cnt, 32'h0);
        check("wrap_x2", w_rd1, 32'h0000_0055);
        check("wrap_p2_x0", w_rd2, 32'h0);
        check("wrap_result", w_res, 32'h0);
        @(negedge clk);
        check("wrap_cnt_hold", w_cnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
